// File: rtl/tag_frame_builder.sv
// Tag frame builder: serialises preamble, payload, CRC-4 and a forced-low gap onto sig.
// Define MANCHESTER_EN for Manchester-coded PRE/PAY/CRC bits; the default build sends NRZ.
module tag_frame_builder #(
    parameter int unsigned      BIT_CYCLES = 100_000,
    parameter int unsigned      PRE_W      = 7,
    parameter logic [PRE_W-1:0] PREAMBLE   = 7'b1010111,
    parameter int unsigned      PAYLOAD_W  = 12,
    parameter int unsigned      GAP_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 sig,
    output logic                 busy,
    output logic                 bit_start,
    output logic                 frame_done
);

    localparam int unsigned CRC_W     = 4;
    localparam int unsigned FRAME_W   = PRE_W + PAYLOAD_W;
    localparam int unsigned TMR_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned MAX_A     = (PRE_W > PAYLOAD_W) ? PRE_W : PAYLOAD_W;
    localparam int unsigned MAX_B     = (GAP_BITS > CRC_W) ? GAP_BITS : CRC_W;
    localparam int unsigned MAX_FIELD = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned IDX_W     = $clog2(MAX_FIELD);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PRE_W - 1);
    localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(PAYLOAD_W - 1);
    localparam logic [IDX_W-1:0] CRC_LAST = IDX_W'(CRC_W - 1);
    localparam logic [IDX_W-1:0] GAP_LAST = IDX_W'(GAP_BITS - 1);
    localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;
`ifdef MANCHESTER_EN
    localparam logic [TMR_W-1:0] HALF     = TMR_W'(BIT_CYCLES / 2);
`endif

    typedef enum logic [2:0] {IDLE, PRE, PAY, CRC, GAP} state_t;

    state_t               state, state_d;
    logic [TMR_W-1:0]     timer, timer_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [FRAME_W-1:0]   frame, frame_d;
    logic [CRC_W-1:0]     crc, crc_d;
    logic                 sig_d, busy_d, bit_start_d, frame_done_d, in_ready_d;
    logic                 bit_end, fb, active, cur_bit;

    // Next-state and next-output logic; outputs are derived from next-state values and then registered
    always_comb begin
        state_d      = state;
        timer_d      = timer;
        idx_d        = idx;
        frame_d      = frame;
        crc_d        = crc;
        frame_done_d = 1'b0;
        bit_end      = (timer == TMR_LAST);
        fb           = crc[CRC_W-1] ^ frame[FRAME_W-1];

        if (state == IDLE) begin
            if (in_valid && in_ready) begin
                frame_d = {PREAMBLE, in_data};
                crc_d   = '0;
                timer_d = '0;
                idx_d   = '0;
                state_d = PRE;
            end
        end else begin
            timer_d = bit_end ? '0 : timer + TMR_W'(1);
            if (bit_end) begin
                idx_d = idx + IDX_W'(1);
                case (state)
                    PRE: begin
                        frame_d = {frame[FRAME_W-2:0], 1'b0};
                        if (idx == PRE_LAST) begin
                            idx_d   = '0;
                            state_d = PAY;
                        end
                    end
                    PAY: begin
                        frame_d = {frame[FRAME_W-2:0], 1'b0};
                        crc_d   = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
                        if (idx == PAY_LAST) begin
                            idx_d   = '0;
                            state_d = CRC;
                        end
                    end
                    CRC: begin
                        // CRC is final once PAY ends; shifting it out sends crc[3] first
                        crc_d = {crc[CRC_W-2:0], 1'b0};
                        if (idx == CRC_LAST) begin
                            idx_d   = '0;
                            state_d = GAP;
                        end
                    end
                    GAP: begin
                        if (idx == GAP_LAST) begin
                            idx_d        = '0;
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        active  = (state_d == PRE) || (state_d == PAY) || (state_d == CRC);
        cur_bit = (state_d == CRC) ? crc_d[CRC_W-1] : frame_d[FRAME_W-1];
`ifdef MANCHESTER_EN
        sig_d   = active & (cur_bit ^ (timer_d >= HALF));
`else
        sig_d   = active & cur_bit;
`endif
        bit_start_d = active && (timer_d == '0);
        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            idx        <= '0;
            frame      <= '0;
            crc        <= '0;
            sig        <= 1'b0;
            busy       <= 1'b0;
            bit_start  <= 1'b0;
            frame_done <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            idx        <= idx_d;
            frame      <= frame_d;
            crc        <= crc_d;
            sig        <= sig_d;
            busy       <= busy_d;
            bit_start  <= bit_start_d;
            frame_done <= frame_done_d;
            in_ready   <= in_ready_d;
        end
    end

endmodule
